// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream input and instruction-memory write bus of the program loader
interface instr_loader_if #(parameter int ADDR_WIDTH = 8);
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0] imem_wdata;
  modport master (output in_data, in_valid, input in_ready, imem_we, imem_addr, imem_wdata);
  modport slave (input in_data, in_valid, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: assembles a length-prefixed big-endian byte stream into imem words, holding the cpu in reset until loaded
module instr_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  instr_loader_if.slave bus,
  output logic cpu_reset,
  output logic done,
  output logic error,
  output logic [ADDR_WIDTH:0] words_loaded
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, DATA, WRITE, RUN, ERR} state_t;
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [1:0] bidx_q, bidx_d;
  logic [ADDR_WIDTH-1:0] widx_q, widx_d;
  logic [ADDR_WIDTH:0] wl_q, wl_d;
  logic acc;
  assign bus.in_ready = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA;
  assign bus.imem_we = state_q == WRITE;
  assign bus.imem_addr = widx_q;
  assign bus.imem_wdata = word_q;
  assign cpu_reset = state_q != RUN;
  assign done = state_q == RUN;
  assign error = state_q == ERR;
  assign words_loaded = wl_q;
  assign acc = bus.in_valid && bus.in_ready;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    word_d = word_q;
    bidx_d = bidx_q;
    widx_d = widx_q;
    wl_d = wl_q;
    case (state_q)
      LEN_HI: if (acc) begin
        len_d[15:8] = bus.in_data;
        state_d = LEN_LO;
      end
      LEN_LO: if (acc) begin
        len_d[7:0] = bus.in_data;
        bidx_d = 2'd0;
        widx_d = '0;
        state_d = (len_d == 16'd0 || {1'b0, len_d} > DEPTH) ? ERR : DATA;
      end
      DATA: if (acc) begin
        word_d = {word_q[23:0], bus.in_data};
        bidx_d = bidx_q + 2'd1;
        state_d = bidx_q == 2'd3 ? WRITE : DATA;
      end
      WRITE: begin
        wl_d = wl_q + (ADDR_WIDTH+1)'(1);
        bidx_d = 2'd0;
        if (17'(widx_q) + 17'd1 == {1'b0, len_q}) state_d = RUN;
        else begin
          widx_d = widx_q + ADDR_WIDTH'(1);
          state_d = DATA;
        end
      end
      default: state_d = state_q;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= LEN_HI;
      len_q <= '0;
      word_q <= '0;
      bidx_q <= '0;
      widx_q <= '0;
      wl_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      word_q <= word_d;
      bidx_q <= bidx_d;
      widx_q <= widx_d;
      wl_q <= wl_d;
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: scoreboard bench; expected imem writes are queued as stream bytes are built
module tb_instr_loader;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cpu_reset, done, error;
  logic [AW:0] words_loaded;
  int errs = 0, checks = 0, we_cnt = 0;
  logic prev_we = 1'b0;
  logic [7:0] stream[$];
  logic [39:0] exp_q[$];
  instr_loader_if #(.ADDR_WIDTH(AW)) ifc ();
  instr_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .bus(ifc.slave),
    .cpu_reset(cpu_reset), .done(done), .error(error), .words_loaded(words_loaded)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ifc.imem_we) begin
      we_cnt++;
      check("we_single_cycle", prev_we, 0);
      check("ready_low_in_write", ifc.in_ready, 0);
      if (exp_q.size() == 0) check("unexpected_write", {ifc.imem_addr, ifc.imem_wdata}, 0);
      else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("waddr", ifc.imem_addr, e[39:32]);
        check("wdata", ifc.imem_wdata, e[31:0]);
      end
    end
    prev_we = ifc.imem_we;
  end
  task automatic add_word(input logic [7:0] addr, input logic [31:0] w);
    exp_q.push_back({addr, w});
    for (int i = 3; i >= 0; i--) stream.push_back(w[i*8 +: 8]);
  endtask
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit acc;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    ifc.in_valid = 1'b1;
    ifc.in_data = b;
    for (int i = 0; i < 20; i++) begin
      acc = ifc.in_ready;
      @(negedge clk);
      if (acc) break;
      if (i == 19) check("accept_timeout", 0, 1);
    end
    ifc.in_valid = 1'b0;
  endtask
  task automatic send_stream(input bit gaps);
    while (stream.size() > 0) send_byte(stream.pop_front(), gaps);
  endtask
  task automatic wait_done(input string tag);
    for (int i = 0; i < 10 && !done; i++) @(negedge clk);
    check(tag, done, 1);
    check({tag, "_cpu_reset"}, cpu_reset, 0);
    check({tag, "_drained"}, exp_q.size(), 0);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    #3;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_we", ifc.imem_we, 0);
    check("rst_words", words_loaded, 0);
    check("rst_flags", {done, error}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", ifc.in_ready, 1);
  endtask
  task automatic run_prog2(input bit gaps);
    int w0;
    w0 = we_cnt;
    stream = {8'h00, 8'h02};
    add_word(8'h00, 32'h20080005);
    add_word(8'h01, 32'h8C090004);
    send_stream(gaps);
    wait_done(gaps ? "gap_done" : "b2b_done");
    check("prog2_words", words_loaded, 2);
    check("prog2_we_cnt", we_cnt - w0, 2);
  endtask
  task automatic bad_header(input logic [7:0] hi, input logic [7:0] lo);
    int w0;
    w0 = we_cnt;
    stream = {hi, lo};
    send_stream(0);
    check("err_flag", error, 1);
    check("err_ready", ifc.in_ready, 0);
    check("err_cpu_reset", cpu_reset, 1);
    stream = {8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    ifc.in_valid = 1'b1;
    repeat (8) @(negedge clk);
    ifc.in_valid = 1'b0;
    stream.delete();
    check("err_no_write", we_cnt - w0, 0);
    check("err_sticky", {error, done}, 2'b10);
  endtask
  initial begin
    ifc.in_valid = 1'b0;
    ifc.in_data = 8'h00;
    @(negedge clk);
    do_reset();
    run_prog2(0);
    begin
      int w0;
      bit rdy;
      w0 = we_cnt;
      rdy = 1'b0;
      ifc.in_valid = 1'b1;
      ifc.in_data = 8'hA5;
      repeat (10) begin
        @(negedge clk);
        rdy |= ifc.in_ready;
      end
      ifc.in_valid = 1'b0;
      check("run_ready_low", rdy, 0);
      check("run_no_write", we_cnt - w0, 0);
      check("run_cpu_reset", cpu_reset, 0);
      check("run_words", words_loaded, 2);
    end
    do_reset();
    run_prog2(1);
    do_reset();
    bad_header(8'h00, 8'h00);
    do_reset();
    bad_header(8'h01, 8'h01);
    do_reset();
    stream = {8'h01, 8'h00};
    for (int i = 0; i < 256; i++) add_word(8'(i), $urandom);
    send_stream(0);
    wait_done("full_done");
    check("full_words", words_loaded, 256);
    do_reset();
    stream = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
    send_stream(0);
    reset = 1'b1;
    #1;
    check("mid_cpu_reset", cpu_reset, 1);
    check("mid_words", words_loaded, 0);
    check("mid_we", ifc.imem_we, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stream = {8'h00, 8'h01};
    add_word(8'h00, 32'h12345678);
    send_stream(0);
    wait_done("restart_done");
    check("restart_words", words_loaded, 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
